// File: rtl/fetch_sequencer_if.sv
// Bundles the fetch sequencer's memory, downstream and redirect signals.
// The sequencer uses modport master; the memory/pipeline side uses slave.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_accept;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [15:0] fetch_count;
  logic        fetch_fault;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_count, fetch_fault,
    input  imem_ready, imem_rdata, instr_accept, redirect_valid, redirect_target
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_count, fetch_fault,
    output imem_ready, imem_rdata, instr_accept, redirect_valid, redirect_target
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch sequencer with branch/jump redirect.
// Define PC_ALIGN_CHECK_EN to trap misaligned redirect targets in FAULT.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input logic                clk,
  input logic                rst_n,
  fetch_sequencer_if.master  bus
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_t;

  state_t      state, next_state;
  logic [31:0] pc;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        instr_valid_q;
  logic [15:0] count_q;
  logic        fault_q;
  logic        req;
  logic [31:0] target;
  logic        misaligned;
  logic        redirect_go;

`ifdef PC_ALIGN_CHECK_EN
  assign target     = bus.redirect_target;
  assign misaligned = |bus.redirect_target[1:0];
`else
  assign target     = bus.redirect_target & 32'hFFFF_FFFC;
  assign misaligned = 1'b0;
`endif

  assign redirect_go = bus.redirect_valid && (state != FAULT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = REQ;
      REQ:     if (bus.imem_ready) next_state = HOLD;
      HOLD:    if (bus.instr_accept) next_state = REQ;
      FAULT:   next_state = FAULT;
      default: next_state = IDLE;
    endcase
    // Redirect overrides any same-cycle memory return or accept transition.
    if (redirect_go) next_state = misaligned ? FAULT : REQ;
  end

  always_comb begin
    req = (state == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_VECTOR;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      count_q       <= '0;
      fault_q       <= 1'b0;
    end else begin
      case (state)
        REQ: begin
          if (!redirect_go && bus.imem_ready) begin
            instr_q       <= bus.imem_rdata;
            instr_pc_q    <= pc;
            instr_valid_q <= 1'b1;
            pc            <= pc + 32'd4;
          end
        end
        HOLD: begin
          // An accept coinciding with a redirect still counts.
          if (bus.instr_accept) begin
            instr_valid_q <= 1'b0;
            count_q       <= count_q + 16'd1;
          end
        end
        default: ;
      endcase
      if (redirect_go) begin
        instr_valid_q <= 1'b0;
        if (misaligned) fault_q <= 1'b1;
        else            pc      <= target;
      end
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.fetch_count = count_q;
  assign bus.fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer (default build unless
// PC_ALIGN_CHECK_EN is defined for both bench and design).
module tb_fetch_sequencer;

  logic clk;
  logic rst_n;
  int unsigned n_cmp;
  int unsigned n_err;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req"},   {31'd0, bus.imem_req}, 32'd0);
    check({tag, ".addr"},  bus.imem_addr, 32'h0);
    check({tag, ".valid"}, {31'd0, bus.instr_valid}, 32'd0);
    check({tag, ".instr"}, bus.instr, 32'h0);
    check({tag, ".ipc"},   bus.instr_pc, 32'h0);
    check({tag, ".cnt"},   {16'd0, bus.fetch_count}, 32'd0);
    check({tag, ".fault"}, {31'd0, bus.fetch_fault}, 32'd0);
  endtask

  // Hold reset across an edge, then release just after a rising edge so the
  // following full cycle is the IDLE cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.imem_ready      = 1'b0;
    bus.imem_rdata      = '0;
    bus.instr_accept    = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    #1;
    check_reset_outputs("rst0");
    step();
    rst_n = 1'b1;

    // Back-to-back fetch with ready and accept always high
    bus.imem_ready   = 1'b1;
    bus.instr_accept = 1'b1;
    check("idle.req", {31'd0, bus.imem_req}, 32'd0);
    for (int unsigned i = 0; i < 3; i++) begin
      bus.imem_rdata = 32'h1000_0000 + i;
      step();
      check("s1.req",  {31'd0, bus.imem_req}, 32'd1);
      check("s1.addr", bus.imem_addr, i * 4);
      check("s1.cnt",  {16'd0, bus.fetch_count}, i);
      step();
      check("s1.hreq",  {31'd0, bus.imem_req}, 32'd0);
      check("s1.valid", {31'd0, bus.instr_valid}, 32'd1);
      check("s1.ipc",   bus.instr_pc, i * 4);
      check("s1.instr", bus.instr, 32'h1000_0000 + i);
    end
    step();
    check("s1.cnt3", {16'd0, bus.fetch_count}, 32'd3);
    check("s1.req4", {31'd0, bus.imem_req}, 32'd1);

    // Memory stalls for 4 cycles in REQ
    bus.imem_ready   = 1'b0;
    bus.instr_accept = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      step();
      check("s2.req",   {31'd0, bus.imem_req}, 32'd1);
      check("s2.addr",  bus.imem_addr, 32'h0000_000C);
      check("s2.valid", {31'd0, bus.instr_valid}, 32'd0);
    end
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    step();
    bus.imem_ready = 1'b0;
    check("s2.instr", bus.instr, 32'hDEAD_BEEF);
    check("s2.ipc",   bus.instr_pc, 32'h0000_000C);

    // Downstream stalls for 5 cycles in HOLD
    for (int unsigned i = 0; i < 5; i++) begin
      step();
      check("s3.instr", bus.instr, 32'hDEAD_BEEF);
      check("s3.ipc",   bus.instr_pc, 32'h0000_000C);
      check("s3.valid", {31'd0, bus.instr_valid}, 32'd1);
      check("s3.req",   {31'd0, bus.imem_req}, 32'd0);
      check("s3.cnt",   {16'd0, bus.fetch_count}, 32'd3);
    end
    bus.instr_accept = 1'b1;
    step();
    bus.instr_accept = 1'b0;
    check("s3.cnt4",  {16'd0, bus.fetch_count}, 32'd4);
    check("s3.vld0",  {31'd0, bus.instr_valid}, 32'd0);
    check("s3.addr",  bus.imem_addr, 32'h0000_0010);

    // Redirect coinciding with imem_ready: data discarded
    bus.imem_ready      = 1'b1;
    bus.imem_rdata      = 32'h0000_0055;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0100;
    step();
    check("s4.req",   {31'd0, bus.imem_req}, 32'd1);
    check("s4.addr",  bus.imem_addr, 32'h0000_0100);
    check("s4.valid", {31'd0, bus.instr_valid}, 32'd0);
    check("s4.instr", bus.instr, 32'hDEAD_BEEF);

    // PC wrap from 0xFFFF_FFFC
    bus.imem_ready      = 1'b0;
    bus.redirect_target = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    check("s4.waddr", bus.imem_addr, 32'hFFFF_FFFC);
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'h0000_000A;
    step();
    check("s4.wipc", bus.instr_pc, 32'hFFFF_FFFC);
    bus.imem_ready   = 1'b0;
    bus.instr_accept = 1'b1;
    step();
    bus.instr_accept = 1'b0;
    check("s4.wrap", bus.imem_addr, 32'h0000_0000);
    check("s4.cnt5", {16'd0, bus.fetch_count}, 32'd5);

    // Redirect in HOLD with same-cycle accept: counted, then redirect
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'h0000_0077;
    step();
    bus.imem_ready = 1'b0;
    check("s5.valid", {31'd0, bus.instr_valid}, 32'd1);
    bus.instr_accept    = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0200;
    step();
    bus.instr_accept   = 1'b0;
    bus.redirect_valid = 1'b0;
    check("s5.cnt6",  {16'd0, bus.fetch_count}, 32'd6);
    check("s5.addr",  bus.imem_addr, 32'h0000_0200);
    check("s5.vld0",  {31'd0, bus.instr_valid}, 32'd0);
    check("s5.req",   {31'd0, bus.imem_req}, 32'd1);

    // Misaligned redirect target
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0102;
    step();
    bus.redirect_valid = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    check("s6.fault", {31'd0, bus.fetch_fault}, 32'd1);
    check("s6.req",   {31'd0, bus.imem_req}, 32'd0);
    bus.imem_ready      = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0300;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      check("s6.hreq",   {31'd0, bus.imem_req}, 32'd0);
      check("s6.hfault", {31'd0, bus.fetch_fault}, 32'd1);
    end
    bus.imem_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
`else
    check("s6.addr",  bus.imem_addr, 32'h0000_0100);
    check("s6.fault", {31'd0, bus.fetch_fault}, 32'd0);
    check("s6.req",   {31'd0, bus.imem_req}, 32'd1);
`endif

    // Asynchronous reset mid-REQ and mid-HOLD
    do_reset();
    check("s7.idle", {31'd0, bus.imem_req}, 32'd0);
    step();
    check("s7.req", {31'd0, bus.imem_req}, 32'd1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("s7.mreq");
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'h0000_0099;
    step();
    rst_n = 1'b1;
    check("s7.idle2", {31'd0, bus.imem_req}, 32'd0);
    check("s7.nvld",  {31'd0, bus.instr_valid}, 32'd0);
    step();
    check("s7.raddr", bus.imem_addr, 32'h0000_0000);
    check("s7.rreq",  {31'd0, bus.imem_req}, 32'd1);
    step();
    bus.imem_ready = 1'b0;
    check("s7.hvld", {31'd0, bus.instr_valid}, 32'd1);
    check("s7.hins", bus.instr, 32'h0000_0099);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("s7.mhold");
    step();
    rst_n = 1'b1;
    step();
    check("s7.restart", bus.imem_addr, 32'h0000_0000);
    check("s7.rstreq",  {31'd0, bus.imem_req}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
